hamming_secded_stream_decoder: RTL

Parametrised, pipelined SECDED Hamming decoder for streaming codewords. It generalises the fixed 12/8 single-error corrector to any data width and adds an overall-parity bit for double-error detection, a valid/ready handshake with back-pressure, a detect-only mode and saturating error counters. It sits between the link/memory read path and downstream consumers, one codeword per cycle.

---
 rtl/hamming_secded_stream_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hamming_secded_stream_decoder.sv
// Pipelined SECDED Hamming decoder for a valid/ready codeword stream.
// Stage A latches the codeword with its syndrome and overall parity; stage B holds the decoded result.
module hamming_secded_stream_decoder #(
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 16,
   localparam int R      = $clog2(DATA_W + $clog2(DATA_W) + 1),
   localparam int N      = DATA_W + R,
   localparam int CW_W   = N + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_code,
   input  logic              correct_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_single,
   output logic              out_double,
   output logic [R-1:0]      out_syndrome,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  cnt_single,
   output logic [CNT_W-1:0]  cnt_double
);

   localparam logic [R-1:0] N_R = R'(N);

   logic              vld_p0;
   logic [CW_W-1:0]   code_p0;
   logic              corr_p0;
   logic [R-1:0]      syn_p0;
   logic              pall_p0;
   logic              ready_p0;
   logic              ready_p1;
   logic              fire_out;
   logic [CW_W-1:0]   flip_mask;
   logic              single_c;
   logic              double_c;
   logic [DATA_W-1:0] data_c;

   function automatic logic [R-1:0] calc_syndrome(input logic [CW_W-1:0] code);
      logic [R-1:0] s;
      s = '0;
      for (int p = 1; p <= N; p++) begin
         if (code[p-1]) s = s ^ R'(p);
      end
      return s;
   endfunction

   // Data bits occupy every non-power-of-two position, lowest position first.
   function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] code);
      logic [DATA_W-1:0] d;
      int                j;
      d = '0;
      j = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = code[p-1];
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

   assign ready_p1 = ~out_valid | out_ready;
   assign ready_p0 = ~vld_p0 | ready_p1;
   assign in_ready = ready_p0;
   assign fire_out = out_valid & out_ready;

   // ---- stage A: capture codeword, syndrome and overall parity ----
   always_ff @(posedge clk) begin
      if (in_valid && ready_p0) begin
         code_p0 <= in_code;
         corr_p0 <= correct_en;
         syn_p0  <= calc_syndrome(in_code);
         pall_p0 <= ^in_code;
      end
   end

   // Syndrome beyond N with odd parity is an odd multi-bit error, treated as uncorrectable.
   always_comb begin
      flip_mask = '0;
      single_c  = 1'b0;
      double_c  = 1'b0;
      if (syn_p0 == '0) begin
         single_c = pall_p0;
      end else if (pall_p0 && (syn_p0 <= N_R)) begin
         single_c = 1'b1;
         if (corr_p0) flip_mask = {{(CW_W-1){1'b0}}, 1'b1} << (syn_p0 - R'(1));
      end else begin
         double_c = 1'b1;
      end
      data_c = extract_data(code_p0 ^ flip_mask);
   end

   // ---- stage B: decoded output register and error counters ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0       <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_single   <= 1'b0;
         out_double   <= 1'b0;
         out_syndrome <= '0;
         cnt_single   <= '0;
         cnt_double   <= '0;
      end else begin
         if (ready_p0) vld_p0 <= in_valid;
         if (ready_p1) begin
            out_valid <= vld_p0;
            if (vld_p0) begin
               out_data     <= data_c;
               out_single   <= single_c;
               out_double   <= double_c;
               out_syndrome <= syn_p0;
            end
         end
         if (cnt_clear) begin
            cnt_single <= '0;
            cnt_double <= '0;
         end else begin
            if (fire_out && out_single) cnt_single <= sat_inc(cnt_single);
            if (fire_out && out_double) cnt_double <= sat_inc(cnt_double);
         end
      end
   end

endmodule
